gip_boot_rom_fetch: RTL and testbench

GIP_BOOT_ROM_FETCH -- requirements
Module: gip_boot_rom_fetch

---
 rtl/gip_boot_rom_fetch.sv | 97 +++++++++
 tb/tb_gip_boot_rom_fetch.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gip_boot_rom_fetch.sv
// Boot ROM burst fetcher: turns {address, length} requests into one-word ROM reads and
// returns the words through a 3-entry credit-limited buffer with a per-burst last flag.
module gip_boot_rom_fetch (
    input  logic        rom_clock,
    input  logic        rom_reset,
    input  logic        fetch_req,
    input  logic [11:0] fetch_address,
    input  logic [2:0]  fetch_length,
    output logic        fetch_ack,
    output logic        fetch_data_valid,
    output logic [31:0] fetch_data,
    output logic        fetch_data_last,
    input  logic        fetch_data_ready,
    output logic        busy,
    output logic [11:0] rom_address,
    output logic        rom_read,
    input  logic [31:0] rom_read_data
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e      state_q;
    logic [11:0] addr_q;
    logic [2:0]  remaining_q;
    logic        inflight_q;
    logic        inflight_last_q;
    logic [32:0] fifo_q [3];
    logic [1:0]  rd_ptr_q;
    logic [1:0]  wr_ptr_q;
    logic [1:0]  count_q;

    logic        credit_ok;
    logic        push;
    logic        pop;
    logic [32:0] head;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        // A read may issue only if its word is guaranteed a slot, counting the one in flight.
        credit_ok        = ({1'b0, count_q} + {2'b00, inflight_q}) <= 3'd2;
        fetch_ack        = fetch_req && (state_q == StIdle) && !rom_reset;
        rom_read         = (state_q == StBurst) && credit_ok && !rom_reset;
        rom_address      = addr_q;
        push             = inflight_q;
        fetch_data_valid = (count_q != 2'd0);
        pop              = fetch_data_valid && fetch_data_ready;
        head             = fifo_q[rd_ptr_q];
        fetch_data       = fetch_data_valid ? head[32:1] : 32'd0;
        fetch_data_last  = fetch_data_valid && head[0];
        busy             = (state_q == StBurst) || inflight_q || fetch_data_valid;
    end

    always_ff @(posedge rom_clock) begin
        if (rom_reset) begin
            state_q         <= StIdle;
            addr_q          <= 12'd0;
            remaining_q     <= 3'd0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rd_ptr_q        <= 2'd0;
            wr_ptr_q        <= 2'd0;
            count_q         <= 2'd0;
        end else begin
            if (fetch_ack) begin
                state_q     <= StBurst;
                addr_q      <= fetch_address;
                remaining_q <= fetch_length;
            end
            if (rom_read) begin
                addr_q          <= addr_q + 12'd1;
                inflight_last_q <= (remaining_q == 3'd0);
                if (remaining_q == 3'd0) begin
                    state_q <= StIdle;
                end else begin
                    remaining_q <= remaining_q - 3'd1;
                end
            end
            inflight_q <= rom_read;
            if (push) begin
                fifo_q[wr_ptr_q] <= {rom_read_data, inflight_last_q};
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_gip_boot_rom_fetch.sv
// Bench for gip_boot_rom_fetch: a transaction-level model (pending reads, undelivered words)
// checks every cycle, plus directed scenarios for latency, wrap, backpressure and reset.
module tb_gip_boot_rom_fetch;

    logic        rom_clock = 1'b0;
    logic        rom_reset;
    logic        fetch_req;
    logic [11:0] fetch_address;
    logic [2:0]  fetch_length;
    logic        fetch_ack;
    logic        fetch_data_valid;
    logic [31:0] fetch_data;
    logic        fetch_data_last;
    logic        fetch_data_ready;
    logic        busy;
    logic [11:0] rom_address;
    logic        rom_read;
    logic [31:0] rom_read_data;

    gip_boot_rom_fetch dut (
        .rom_clock        (rom_clock),
        .rom_reset        (rom_reset),
        .fetch_req        (fetch_req),
        .fetch_address    (fetch_address),
        .fetch_length     (fetch_length),
        .fetch_ack        (fetch_ack),
        .fetch_data_valid (fetch_data_valid),
        .fetch_data       (fetch_data),
        .fetch_data_last  (fetch_data_last),
        .fetch_data_ready (fetch_data_ready),
        .busy             (busy),
        .rom_address      (rom_address),
        .rom_read         (rom_read),
        .rom_read_data    (rom_read_data)
    );

    always #5 rom_clock = ~rom_clock;

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return {~a[7:0], a, a ^ 12'h5A3};
    endfunction

    // ROM answers the cycle after a read; otherwise the data bus carries junk.
    always @(posedge rom_clock) begin
        rom_read_data <= rom_read ? rom_word(rom_address) : $urandom;
    end

    typedef struct {
        logic [11:0] addr;
        logic        last;
        int          cyc;
    } word_t;

    word_t       read_q[$];
    word_t       out_q[$];
    logic [11:0] next_addr;
    int          cyc;
    int          n_checks;
    int          n_fail;

    logic        o_ack, o_read, o_valid, o_last, o_busy;
    logic [11:0] o_addr;
    logic [31:0] o_data;

    // One clock: settle, sample, compare against the model, advance the model.
    task automatic cycle();
        word_t       w;
        logic        exp_ack, exp_read, exp_valid, exp_busy;
        logic [11:0] exp_addr;
        #1;
        o_ack   = fetch_ack;
        o_read  = rom_read;
        o_valid = fetch_data_valid;
        o_last  = fetch_data_last;
        o_busy  = busy;
        o_addr  = rom_address;
        o_data  = fetch_data;

        exp_ack  = fetch_req && !rom_reset && (read_q.size() == 0);
        exp_read = !rom_reset && (read_q.size() > 0) && (out_q.size() <= 2);
        exp_addr = (read_q.size() > 0) ? read_q[0].addr : next_addr;
        exp_valid = (out_q.size() > 0) && (out_q[0].cyc <= cyc - 2);
        exp_busy  = (read_q.size() > 0) || (out_q.size() > 0);

        n_checks++;
        if (o_ack !== exp_ack) begin
            n_fail++;
            $display("FAIL model_ack cyc=%0d got=%b exp=%b", cyc, o_ack, exp_ack);
        end
        n_checks++;
        if (o_read !== exp_read) begin
            n_fail++;
            $display("FAIL model_rom_read cyc=%0d got=%b exp=%b", cyc, o_read, exp_read);
        end
        if (!rom_reset) begin
            n_checks++;
            if (o_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL model_rom_address cyc=%0d got=%h exp=%h", cyc, o_addr, exp_addr);
            end
            n_checks++;
            if (o_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL model_valid cyc=%0d got=%b exp=%b", cyc, o_valid, exp_valid);
            end
            n_checks++;
            if (o_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL model_busy cyc=%0d got=%b exp=%b", cyc, o_busy, exp_busy);
            end
            if (exp_valid) begin
                n_checks++;
                if (o_data !== rom_word(out_q[0].addr) || o_last !== out_q[0].last) begin
                    n_fail++;
                    $display("FAIL model_data cyc=%0d got=%h/%b exp=%h/%b", cyc, o_data, o_last,
                             rom_word(out_q[0].addr), out_q[0].last);
                end
            end
        end

        if (rom_reset) begin
            read_q.delete();
            out_q.delete();
            next_addr = 12'd0;
        end else begin
            if (exp_ack) begin
                for (int i = 0; i <= int'(fetch_length); i++) begin
                    w.addr = fetch_address + 12'(i);
                    w.last = (i == int'(fetch_length));
                    w.cyc  = 0;
                    read_q.push_back(w);
                end
            end
            if (exp_read) begin
                w = read_q.pop_front();
                w.cyc = cyc;
                out_q.push_back(w);
                next_addr = w.addr + 12'd1;
            end
            if (exp_valid && fetch_data_ready) begin
                void'(out_q.pop_front());
            end
        end
        cyc++;
        @(negedge rom_clock);
    endtask

    task automatic drain();
        int k;
        fetch_req = 1'b0;
        fetch_data_ready = 1'b1;
        k = 0;
        while ((read_q.size() > 0 || out_q.size() > 0) && k < 40) begin
            cycle();
            k++;
        end
        cycle();
        n_checks++;
        if (read_q.size() != 0 || out_q.size() != 0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout pending=%0d busy=%b exp_busy=0",
                     read_q.size() + out_q.size(), o_busy);
        end
    endtask

    task automatic test_reset();
        rom_reset = 1'b1;
        fetch_req = 1'b1;
        fetch_address = 12'h3A5;
        fetch_length = 3'd2;
        fetch_data_ready = 1'b0;
        cycle();
        cycle();
        rom_reset = 1'b0;
        fetch_req = 1'b0;
        cycle();
        n_checks++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || o_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got valid=%b last=%b data=%h exp 0/0/0",
                     o_valid, o_last, o_data);
        end
        n_checks++;
        if (o_busy !== 1'b0 || o_addr !== 12'd0 || o_read !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rom got busy=%b addr=%h read=%b exp 0/000/0",
                     o_busy, o_addr, o_read);
        end
    endtask

    task automatic test_single();
        fetch_req = 1'b1;
        fetch_address = 12'h010;
        fetch_length = 3'd0;
        fetch_data_ready = 1'b1;
        cycle();
        n_checks++;
        if (o_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ack got=%b exp=1", o_ack);
        end
        fetch_req = 1'b0;
        cycle();
        n_checks++;
        if (o_read !== 1'b1 || o_addr !== 12'h010) begin
            n_fail++;
            $display("FAIL single_read got read=%b addr=%h exp 1/010", o_read, o_addr);
        end
        cycle();
        cycle();
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== rom_word(12'h010) || o_last !== 1'b1) begin
            n_fail++;
            $display("FAIL single_word got %b/%h/%b exp 1/%h/1", o_valid, o_data, o_last,
                     rom_word(12'h010));
        end
        cycle();
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy got=%b exp=0", o_busy);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] a;
        fetch_req = 1'b1;
        fetch_address = 12'hFFE;
        fetch_length = 3'd7;
        fetch_data_ready = 1'b1;
        cycle();
        fetch_req = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            cycle();
            a = 12'hFFE + 12'(k - 1);
            n_checks++;
            if (k <= 8 && (o_read !== 1'b1 || o_addr !== a)) begin
                n_fail++;
                $display("FAIL wrap_read k=%0d got %b/%h exp 1/%h", k, o_read, o_addr, a);
            end else if (k > 8 && o_read !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_read_stop k=%0d got=%b exp=0", k, o_read);
            end
            a = 12'hFFE + 12'(k - 3);
            n_checks++;
            if (k >= 3 && k <= 10 && (o_valid !== 1'b1 || o_data !== rom_word(a)
                                      || o_last !== (k == 10))) begin
                n_fail++;
                $display("FAIL wrap_word k=%0d got %b/%h/%b exp 1/%h/%b", k, o_valid, o_data,
                         o_last, rom_word(a), (k == 10));
            end else if (k == 11 && o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_tail k=%0d got=%b exp=0", k, o_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int          got;
        int          n103;
        logic [11:0] a;
        fetch_req = 1'b1;
        fetch_address = 12'h100;
        fetch_length = 3'd3;
        fetch_data_ready = 1'b0;
        cycle();
        fetch_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            a = 12'h100 + 12'(k - 1);
            n_checks++;
            if (k <= 3 && (o_read !== 1'b1 || o_addr !== a)) begin
                n_fail++;
                $display("FAIL bp_read k=%0d got %b/%h exp 1/%h", k, o_read, o_addr, a);
            end else if (k > 3 && o_read !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall k=%0d got=%b exp=0", k, o_read);
            end
            if (k >= 3) begin
                n_checks++;
                if (o_valid !== 1'b1 || o_data !== rom_word(12'h100) || o_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_head k=%0d got %b/%h/%b exp 1/%h/0", k, o_valid, o_data,
                             o_last, rom_word(12'h100));
                end
            end
        end
        fetch_data_ready = 1'b1;
        got = 0;
        n103 = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (o_read && o_addr == 12'h103) n103++;
            if (o_valid) begin
                a = 12'h100 + 12'(got);
                n_checks++;
                if (o_data !== rom_word(a) || o_last !== (got == 3)) begin
                    n_fail++;
                    $display("FAIL bp_order n=%0d got %h/%b exp %h/%b", got, o_data, o_last,
                             rom_word(a), (got == 3));
                end
                got++;
            end
        end
        n_checks++;
        if (got != 4 || n103 != 1) begin
            n_fail++;
            $display("FAIL bp_count got words=%0d reads103=%0d exp 4/1", got, n103);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_a[3];
        logic        exp_l[3];
        int          got;
        exp_a[0] = 12'h020; exp_l[0] = 1'b0;
        exp_a[1] = 12'h021; exp_l[1] = 1'b1;
        exp_a[2] = 12'h040; exp_l[2] = 1'b1;
        fetch_req = 1'b1;
        fetch_address = 12'h020;
        fetch_length = 3'd1;
        fetch_data_ready = 1'b1;
        got = 0;
        cycle();
        fetch_address = 12'h040;
        fetch_length = 3'd0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (k <= 3) begin
                n_checks++;
                if (o_ack !== (k == 3)) begin
                    n_fail++;
                    $display("FAIL b2b_ack k=%0d got=%b exp=%b", k, o_ack, (k == 3));
                end
            end
            if (k == 3) fetch_req = 1'b0;
            if (o_valid) begin
                n_checks++;
                if (got > 2 || o_data !== rom_word(exp_a[got]) || o_last !== exp_l[got]) begin
                    n_fail++;
                    $display("FAIL b2b_order n=%0d got %h/%b", got, o_data, o_last);
                end
                got++;
            end
        end
        n_checks++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d exp=3", got);
        end
    endtask

    task automatic test_reset_mid_burst();
        int seen;
        fetch_req = 1'b1;
        fetch_address = 12'h200;
        fetch_length = 3'd7;
        fetch_data_ready = 1'b0;
        cycle();
        fetch_req = 1'b0;
        cycle();
        cycle();
        rom_reset = 1'b1;
        cycle();
        rom_reset = 1'b0;
        cycle();
        n_checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_read !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid got valid=%b busy=%b read=%b exp 0/0/0", o_valid, o_busy,
                     o_read);
        end
        fetch_data_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (o_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_mid_leak got words=%0d exp=0", seen);
        end
        test_single();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            rom_reset = ($urandom_range(0, 199) == 0);
            fetch_req = ($urandom_range(0, 2) == 0);
            fetch_address = 12'($urandom);
            fetch_length = 3'($urandom);
            fetch_data_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rom_reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        next_addr = 12'd0;
        rom_reset = 1'b1;
        fetch_req = 1'b0;
        fetch_address = 12'd0;
        fetch_length = 3'd0;
        fetch_data_ready = 1'b0;
        @(negedge rom_clock);
        test_reset();
        test_single();
        drain();
        test_wrap();
        drain();
        test_backpressure();
        drain();
        test_back_to_back();
        drain();
        test_reset_mid_burst();
        drain();
        test_random();
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
